fuzzy_mf_sched: RTL and testbench

FUZZY_MF_SCHED -- requirements
Module: fuzzy_mf_sched

---
 rtl/fuzzy_mf_sched_pkg.sv | 47 ++++
 rtl/fuzzy_mf_sched_if.sv | 26 ++
 rtl/fuzzy_mf_sched_trap.sv | 37 +++
 rtl/fuzzy_mf_sched.sv | 134 +++++++++++++
 tb/tb_fuzzy_mf_sched.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fuzzy_mf_sched_pkg.sv
// Shared types and constants for the fuzzy membership-function scheduler.
// Holds the set index, FSM encoding, trapezoid parameter record and reset defaults.
package fuzzy_mf_sched_pkg;

    localparam int N_SETS = 3;

    typedef enum logic [1:0] {
        SET_NEG  = 2'd0,
        SET_ZERO = 2'd1,
        SET_POS  = 2'd2
    } set_idx_t;

    localparam logic [1:0] SET_LAST = 2'(N_SETS - 1);

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_EVAL = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    localparam logic [15:0] MU_ONE       = 16'h7FFF;
    localparam logic [3:0]  CFG_ADDR_MAX = 4'd11;

    typedef struct packed {
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic signed [7:0] c;
        logic signed [7:0] d;
    } trap_param_t;

    localparam trap_param_t DEF_NEG  = '{a: 8'sh80, b: 8'sh80, c: 8'shC0, d: 8'sh00};
    localparam trap_param_t DEF_ZERO = '{a: 8'shC0, b: 8'sh00, c: 8'sh00, d: 8'sh40};
    localparam trap_param_t DEF_POS  = '{a: 8'sh00, b: 8'sh40, c: 8'sh7F, d: 8'sh7F};

    function automatic trap_param_t set_field(input trap_param_t p, input logic [1:0] f,
                                              input logic signed [7:0] v);
        trap_param_t r;
        r = p;
        case (f)
            2'd0:    r.a = v;
            2'd1:    r.b = v;
            2'd2:    r.c = v;
            default: r.d = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fuzzy_mf_sched_if.sv
// Sample/result handshake and configuration bus of the membership-function scheduler.
interface fuzzy_mf_sched_if;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic signed [7:0] cfg_wdata;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x_in;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       mu_neg;
    logic [15:0]       mu_zero;
    logic [15:0]       mu_pos;
    logic              busy;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, x_in, out_ready,
        output cfg_err, in_ready, out_valid, mu_neg, mu_zero, mu_pos, busy
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, x_in, out_ready,
        input  cfg_err, in_ready, out_valid, mu_neg, mu_zero, mu_pos, busy
    );
endinterface

// File: rtl/fuzzy_mf_sched_trap.sv
// Combinational trapezoidal membership function, Q1.15 result, truncating division.
// Flat top [b,c] yields MU_ONE; outside (a,d) yields zero; slopes are linear.
module fuzzy_mf_sched_trap
    import fuzzy_mf_sched_pkg::*;
(
    input  logic signed [7:0] x,
    input  logic signed [7:0] a,
    input  logic signed [7:0] b,
    input  logic signed [7:0] c,
    input  logic signed [7:0] d,
    output logic [15:0]       mu
);

    logic [7:0] num_s;
    logic [7:0] den_s;

    // Differences never exceed 255 inside a slope, so 8-bit wraparound gives the exact magnitude.
    always_comb begin
        num_s = 8'd0;
        den_s = 8'd1;
        mu    = 16'd0;
        if ((x >= b) && (x <= c)) begin
            mu = MU_ONE;
        end else if ((x <= a) || (x >= d)) begin
            mu = 16'd0;
        end else if (x < b) begin
            num_s = 8'(x - a);
            den_s = 8'(b - a);
            mu    = 16'({num_s, 15'd0} / {15'd0, den_s});
        end else begin
            num_s = 8'(d - x);
            den_s = 8'(d - c);
            mu    = 16'({num_s, 15'd0} / {15'd0, den_s});
        end
    end

endmodule

// File: rtl/fuzzy_mf_sched.sv
// Evaluates neg/zero/pos membership of one captured sample by time-multiplexing
// a single trapezoid over the three parameter sets; results held until consumed.
module fuzzy_mf_sched
    import fuzzy_mf_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fuzzy_mf_sched_if.slave bus
);

    fsm_state_t        state_r;
    set_idx_t          idx_r;
    logic signed [7:0] x_r;
    trap_param_t       neg_r, zero_r, pos_r, sel_s;
    logic [15:0]       mu_s, mu_neg_r, mu_zero_r, mu_pos_r;
    logic              out_valid_r, cfg_err_r;
    logic              accept_s, cfg_ok_s;

    function automatic set_idx_t next_idx(input set_idx_t i);
        case (i)
            SET_NEG:  return SET_ZERO;
            SET_ZERO: return SET_POS;
            default:  return SET_POS;
        endcase
    endfunction

    assign accept_s = (state_r == ST_IDLE) && bus.in_valid;
    assign cfg_ok_s = bus.cfg_we && (state_r == ST_IDLE) && (bus.cfg_addr <= CFG_ADDR_MAX);

    // Sequencer: capture, walk idx over the sets, then hold results until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= SET_NEG;
            x_r         <= 8'sd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_EVAL;
                        idx_r   <= SET_NEG;
                        x_r     <= bus.x_in;
                    end
                end
                ST_EVAL: begin
                    if (idx_r == SET_LAST) begin
                        state_r     <= ST_DONE;
                        idx_r       <= SET_NEG;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= next_idx(idx_r);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= SET_NEG;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Parameter select feeding the shared trapezoid.
    always_comb begin
        sel_s = neg_r;
        case (idx_r)
            SET_NEG:  sel_s = neg_r;
            SET_ZERO: sel_s = zero_r;
            SET_POS:  sel_s = pos_r;
            default:  sel_s = neg_r;
        endcase
    end

    fuzzy_mf_sched_trap u_trap (
        .x  (x_r),
        .a  (sel_s.a),
        .b  (sel_s.b),
        .c  (sel_s.c),
        .d  (sel_s.d),
        .mu (mu_s)
    );

    // Result registers; sets not yet visited in this pass keep their old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mu_neg_r  <= 16'd0;
            mu_zero_r <= 16'd0;
            mu_pos_r  <= 16'd0;
        end else if (state_r == ST_EVAL) begin
            case (idx_r)
                SET_NEG:  mu_neg_r  <= mu_s;
                SET_ZERO: mu_zero_r <= mu_s;
                SET_POS:  mu_pos_r  <= mu_s;
                default:  mu_pos_r  <= mu_pos_r;
            endcase
        end
    end

    // Parameter file writes (IDLE only) and rejected-write pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_r     <= DEF_NEG;
            zero_r    <= DEF_ZERO;
            pos_r     <= DEF_POS;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= bus.cfg_we && !cfg_ok_s;
            if (cfg_ok_s) begin
                case (bus.cfg_addr[3:2])
                    2'd0:    neg_r  <= set_field(neg_r,  bus.cfg_addr[1:0], bus.cfg_wdata);
                    2'd1:    zero_r <= set_field(zero_r, bus.cfg_addr[1:0], bus.cfg_wdata);
                    2'd2:    pos_r  <= set_field(pos_r,  bus.cfg_addr[1:0], bus.cfg_wdata);
                    default: pos_r  <= pos_r;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.cfg_err   = cfg_err_r;
    assign bus.mu_neg    = mu_neg_r;
    assign bus.mu_zero   = mu_zero_r;
    assign bus.mu_pos    = mu_pos_r;

endmodule

// File: tb/tb_fuzzy_mf_sched.sv
// Scoreboard bench for fuzzy_mf_sched: directed samples push expected mu triples,
// a monitor pops and compares whenever a result is consumed.
module tb_fuzzy_mf_sched;
    import fuzzy_mf_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fuzzy_mf_sched_if bus ();

    fuzzy_mf_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [15:0] z;
        logic [15:0] p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] n, input logic [15:0] z, input logic [15:0] p);
        exp_t e;
        e.n = n; e.z = z; e.p = p;
        return e;
    endfunction

    // Monitor: every consumed result must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got %h/%h/%h expected none",
                             bus.mu_neg, bus.mu_zero, bus.mu_pos);
                end else begin
                    mon_e = sb.pop_front();
                    check("mu_neg",  bus.mu_neg,  mon_e.n);
                    check("mu_zero", bus.mu_zero, mon_e.z);
                    check("mu_pos",  bus.mu_pos,  mon_e.p);
                end
            end
        end
    end

    task automatic accept(input logic signed [7:0] x, input exp_t e);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", bus.in_ready);
        end
        bus.x_in     = x;
        bus.in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic signed [7:0] data);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
    endtask

    task automatic check_err_pulse(input string name);
        @(negedge clk);
        check({name, "_err_hi"}, {15'd0, bus.cfg_err}, 16'd1);
        @(negedge clk);
        check({name, "_err_lo"}, {15'd0, bus.cfg_err}, 16'd0);
    endtask

    initial begin
        int t;
        bus.cfg_we = 1'b0; bus.cfg_addr = 4'd0; bus.cfg_wdata = 8'sd0;
        bus.in_valid = 1'b0; bus.x_in = 8'sd0; bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_busy",      {15'd0, bus.busy},      16'd0);
        check("rst_cfg_err",   {15'd0, bus.cfg_err},   16'd0);
        check("rst_in_ready",  {15'd0, bus.in_ready},  16'd1);
        check("rst_mu_neg",  bus.mu_neg,  16'd0);
        check("rst_mu_zero", bus.mu_zero, 16'd0);
        check("rst_mu_pos",  bus.mu_pos,  16'd0);
        rst = 1'b0;

        // Default parameters, slopes on neg and zero
        accept(-8'sd32, mk(16'h4000, 16'h4000, 16'h0000));
        wait_idle();

        // Flat top of zero, with latency / in_ready timing
        accept(8'sd0, mk(16'h0000, 16'h7FFF, 16'h0000));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lat_in_ready_lo", {15'd0, bus.in_ready}, 16'd0);
            check("lat_out_valid", {15'd0, bus.out_valid}, (k == 3) ? 16'd1 : 16'd0);
        end
        @(negedge clk);
        check("lat_in_ready_hi", {15'd0, bus.in_ready}, 16'd1);
        check("lat_out_valid_lo", {15'd0, bus.out_valid}, 16'd0);

        // Backpressure: held results, in_valid pulses ignored
        bus.out_ready = 1'b0;
        accept(8'sd32, mk(16'h0000, 16'h4000, 16'h4000));
        t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_rise", {15'd0, bus.out_valid}, 16'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 bus.in_valid = k[0];
            bus.x_in = -8'sd100;
            @(negedge clk);
            check("bp_out_valid", {15'd0, bus.out_valid}, 16'd1);
            check("bp_in_ready",  {15'd0, bus.in_ready},  16'd0);
            check("bp_mu_zero",   bus.mu_zero, 16'h4000);
            check("bp_mu_pos",    bus.mu_pos,  16'h4000);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        repeat (8) @(negedge clk);

        // zero.a = -128 written in IDLE
        cfg_write(4'd4, 8'sh80);
        @(negedge clk);
        check("cfg_ok_err", {15'd0, bus.cfg_err}, 16'd0);
        accept(-8'sd64, mk(16'h7FFF, 16'h4000, 16'h0000));
        wait_idle();
        accept(-8'sd96, mk(16'h7FFF, 16'h2000, 16'h0000));
        wait_idle();

        // Restore zero.a in the same cycle as a sample acceptance
        @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd4; bus.cfg_wdata = 8'shC0;
        bus.x_in = -8'sd32; bus.in_valid = 1'b1;
        sb.push_back(mk(16'h4000, 16'h4000, 16'h0000));
        @(posedge clk);
        #1 bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
        wait_idle();

        // Write during EVAL is rejected
        accept(-8'sd32, mk(16'h4000, 16'h4000, 16'h0000));
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd4; bus.cfg_wdata = 8'sh00;
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        check_err_pulse("eval_wr");
        wait_idle();
        accept(-8'sd32, mk(16'h4000, 16'h4000, 16'h0000));
        wait_idle();

        // Out-of-range address is rejected
        cfg_write(4'd12, 8'sh00);
        check_err_pulse("addr12");
        accept(-8'sd32, mk(16'h4000, 16'h4000, 16'h0000));
        wait_idle();

        // Reset mid-EVAL aborts the sample and restores default parameters
        cfg_write(4'd4, 8'sh80);
        accept(8'sd0, mk(16'h0000, 16'h7FFF, 16'h0000));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_busy",      {15'd0, bus.busy},      16'd0);
        check("arst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("arst_in_ready",  {15'd0, bus.in_ready},  16'd1);
        check("arst_mu_zero",   bus.mu_zero, 16'd0);
        check("arst_mu_neg",    bus.mu_neg,  16'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("arst_no_out", {15'd0, bus.out_valid}, 16'd0);
        end
        accept(-8'sd32, mk(16'h4000, 16'h4000, 16'h0000));
        wait_idle();

        repeat (3) @(negedge clk);
        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
